line_frame_sequencer: RTL and testbench
=======================================

# line_frame_sequencer

Schedules the two 256-pixel ping-pong line banks between the ADC capture side and the UART transmit path. Host command bytes start and stop framing. The block tracks bank ownership so capture never writes a bank being sent. It reads pixels out of the bank being sent and serialises each line into a framed byte stream on a valid/ready interface to the UART transmitter. It sits between the line-buffer RAM, the capture counter and the UART TX.

## Interface
- NPIX, 256: pixels per line
- AW, 8: pixel address width
- DW, 12: ADC sample width, ≤16
- clk  in  1  system clock; every port is synchronous to clk
- rst_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  one-cycle strobe, host byte received
- cmd_data  in  8  host byte: 0x10 single frame, 0x11 continuous, 0x12 stop; other values ignored
- cap_done  in  1  one-cycle strobe, capture finished writing bank cap_bank_sel
- cap_bank_sel  out  1  bank capture writes; reset 0
- rd_en  out  1  line-buffer read strobe; reset 0
- rd_bank  out  1  bank being read; reset 0
- rd_addr  out  AW  pixel address; reset 0
- rd_data  in  DW  pixel data, valid the cycle after rd_en
- tx_valid  out  1  byte available; reset 0
- tx_data  out  8  byte; reset 0
- tx_ready  in  1  UART accepts byte
- busy  out  1  frame in progress; reset 0
- frame_cnt  out  16  frames fully sent, wraps; reset 0
- drop_cnt  out  16  lines discarded, saturates at 0xFFFF; reset 0

## Operation
- Each bank has a state: FREE, READY or BUSY. Both banks reset to FREE.
- On cap_done for bank b = cap_bank_sel:
  - If the other bank is not BUSY: b becomes READY and cap_bank_sel toggles. If the other bank was READY, it becomes FREE and drop_cnt increments (newest line wins).
  - If the other bank is BUSY: b stays FREE, cap_bank_sel is unchanged, and drop_cnt increments.
- Arm logic, one 2-bit mode register (OFF/SINGLE/CONT); reset OFF:
  - 0x10 sets SINGLE.
  - 0x11 sets CONT.
  - 0x12 sets OFF. A frame already in flight completes.
- Sender FSM states: IDLE → SYNC0 → SYNC1 → FETCH → LO → HI → (FETCH | CSUM | TAIL0) → TAIL1 → IDLE.
- IDLE:
  - Leaves IDLE when mode ≠ OFF and a READY bank exists that is not cap_bank_sel.
  - That bank becomes BUSY; rd_bank takes its index and rd_addr = 0; busy = 1.
  - In SINGLE mode, mode returns to OFF on the claim.
- Byte sequence:
  - SYNC0 = 0xC5, SYNC1 = 0xE3.
  - Per pixel: LO = rd_data[7:0], then HI = zero-extended rd_data[DW-1:8].
  - Trailer: TAIL0 = 0xE3, TAIL1 = 0xC5.
- FETCH asserts rd_en for one cycle. The sample is registered the next cycle, and LO presents on the cycle after that.
- After HI is accepted: if rd_addr = NPIX-1, go to CSUM/TAIL0; otherwise rd_addr increments and the FSM returns to FETCH.
- On TAIL1 accept:
  - The bank becomes FREE and frame_cnt increments.
  - busy = 0 and the FSM returns to IDLE.
- Simultaneous events:
  - Bank release is applied before cap_done evaluation in the same cycle, so the other bank counts as FREE.
  - A command in the same cycle as an IDLE claim is applied after the claim. Stop prevents the next frame only.
- Mid-frame reset: all state returns to reset values immediately. A partial frame is abandoned; the host resynchronises on 0xC5E3.

## Timing
- Handshake:
  - A byte transfers on a cycle with tx_valid && tx_ready.
  - tx_data holds while tx_valid && !tx_ready.
  - tx_valid never drops without a transfer.
- Claim to first tx_valid: 1 cycle.
- Pixel overhead: 2 cycles (FETCH + register) before LO.
- Minimum frame with tx_ready tied high: 4 + NPIX·4 cycles (+1 with checksum).
- cap_done to cap_bank_sel toggle: 1 cycle, registered.

## Configuration
- FRAME_CSUM_EN
  - Defined: the CSUM state sends one byte equal to the XOR of every pixel LO and HI byte of the frame, before TAIL0. The frame is 2+2·NPIX+1+2 bytes.
  - Undefined: the CSUM state and XOR register are absent. The frame is 2+2·NPIX+2 bytes.

## Structure
- Shared package line_pkg holds:
  - the bank state enum (FREE/READY/BUSY) and the sender state enum;
  - command constants CMD_SINGLE/CMD_CONT/CMD_STOP;
  - marker constants SYNC_HI/SYNC_LO = 0xC5/0xE3;
  - NPIX/AW/DW defaults.
- One sub-module, line_bank_arbiter, holds the two bank states, cap_bank_sel, drop_cnt and the claim/release ports. The sender FSM stays at top level.

## Test plan
- Reset, then 0x10; one cap_done with bank 0 holding ramp data i (12-bit); tx_ready=1 → bytes C5 E3 00 00 01 00 … FF 00 E3 C5; frame_cnt=1; no second frame after a further cap_done.
- 0x11; cap_done every 300 cycles; tx_ready=1 → consecutive frames, each sent from the bank capture just left; drop_cnt increments while a send is in progress.
- Two cap_done with no command → drop_cnt=1; 0x10 then sends the second line's data.
- tx_ready toggling 1-of-3 cycles → tx_data stable while stalled; byte order identical to the unstalled run.
- 0x12 at pixel 100 of a CONT frame → frame completes through E3 C5; busy=0; no further frames.
- rst_n low at pixel 50 → all outputs at reset values; next 0x10 frame starts with C5 E3. With FRAME_CSUM_EN and all pixels 0xABC → checksum byte 0x00.

Source files
------------

// File: rtl/line_pkg.sv
// Shared types and constants for the line frame sequencer and its bank arbiter.
// The checksum feature is enabled in line_frame_sequencer via FRAME_CSUM_EN.
package line_pkg;

  localparam int NPIX = 256;
  localparam int AW   = 8;
  localparam int DW   = 12;

  localparam logic [7:0] CMD_SINGLE = 8'h10;
  localparam logic [7:0] CMD_CONT   = 8'h11;
  localparam logic [7:0] CMD_STOP   = 8'h12;

  localparam logic [7:0] SYNC_HI = 8'hC5;
  localparam logic [7:0] SYNC_LO = 8'hE3;

  typedef enum logic [1:0] {
    BANK_FREE  = 2'd0,
    BANK_READY = 2'd1,
    BANK_BUSY  = 2'd2
  } bank_state_e;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_SINGLE = 2'd1,
    MODE_CONT   = 2'd2
  } mode_e;

  // S_LOAD is the cycle in which the RAM output is captured into the sample register.
  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_SYNC0 = 4'd1,
    S_SYNC1 = 4'd2,
    S_FETCH = 4'd3,
    S_LOAD  = 4'd4,
    S_LO    = 4'd5,
    S_HI    = 4'd6,
    S_CSUM  = 4'd7,
    S_TAIL0 = 4'd8,
    S_TAIL1 = 4'd9
  } send_state_e;

  function automatic logic [7:0] csum_next(input logic [7:0] acc, input logic [7:0] data);
    return acc ^ data;
  endfunction

endpackage

// File: rtl/line_bank_arbiter.sv
// Ping-pong bank ownership: tracks FREE/READY/BUSY per bank, the capture target
// bank, and the count of discarded lines.
module line_bank_arbiter
  import line_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cap_done_i,
  input  logic        claim_i,
  input  logic        claim_bank_i,
  input  logic        release_i,
  input  logic        release_bank_i,
  output logic        cap_bank_sel_o,
  output logic [1:0]  bank_ready_o,
  output logic [15:0] drop_cnt_o
);

  bank_state_e bank_q [2];
  bank_state_e bank_d [2];
  logic        sel_q, sel_d;
  logic [15:0] drop_q, drop_d;
  logic        drop_inc_s;
  logic        other_s;

  assign other_s = ~sel_q;

  // Release/claim are applied first so a capture completion sees the updated owner.
  always_comb begin
    bank_d     = bank_q;
    sel_d      = sel_q;
    drop_inc_s = 1'b0;
    if (release_i) begin
      bank_d[release_bank_i] = BANK_FREE;
    end else if (claim_i) begin
      bank_d[claim_bank_i] = BANK_BUSY;
    end else begin
      bank_d = bank_q;
    end
    if (cap_done_i) begin
      if (bank_d[other_s] == BANK_BUSY) begin
        drop_inc_s = 1'b1;
      end else begin
        drop_inc_s      = (bank_d[other_s] == BANK_READY);
        bank_d[other_s] = BANK_FREE;
        bank_d[sel_q]   = BANK_READY;
        sel_d           = ~sel_q;
      end
    end else begin
      sel_d = sel_q;
    end
  end

  assign drop_d = (drop_inc_s && (drop_q != 16'hFFFF)) ? (drop_q + 16'd1) : drop_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        bank_q[i] <= BANK_FREE;
      end
      sel_q  <= 1'b0;
      drop_q <= 16'd0;
    end else begin
      bank_q <= bank_d;
      sel_q  <= sel_d;
      drop_q <= drop_d;
    end
  end

  assign cap_bank_sel_o = sel_q;
  assign bank_ready_o   = {bank_q[1] == BANK_READY, bank_q[0] == BANK_READY};
  assign drop_cnt_o     = drop_q;

endmodule

// File: rtl/line_frame_sequencer.sv
// Sends captured lines from the ping-pong line buffer as framed bytes to the UART.
// Define FRAME_CSUM_EN to append an XOR checksum byte of all pixel bytes before the trailer.
module line_frame_sequencer
  import line_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid_i,
  input  logic [7:0]    cmd_data_i,
  input  logic          cap_done_i,
  output logic          cap_bank_sel_o,
  output logic          rd_en_o,
  output logic          rd_bank_o,
  output logic [AW-1:0] rd_addr_o,
  input  logic [DW-1:0] rd_data_i,
  output logic          tx_valid_o,
  output logic [7:0]    tx_data_o,
  input  logic          tx_ready_i,
  output logic          busy_o,
  output logic [15:0]   frame_cnt_o,
  output logic [15:0]   drop_cnt_o
);

  send_state_e   state_q, state_d;
  mode_e         mode_q, mode_d, mode_claim_s;
  logic          rd_bank_q;
  logic [AW-1:0] rd_addr_q;
  logic [DW-1:0] sample_q;
  logic          busy_q;
  logic [15:0]   frame_cnt_q;
`ifdef FRAME_CSUM_EN
  logic [7:0]    csum_q;
`endif

  logic [1:0]    bank_ready_s;
  logic          claim_s;
  logic          claim_bank_s;
  logic          release_s;
  logic          last_pix_s;
  logic [15:0]   sample_ext_s;

  assign claim_bank_s = ~cap_bank_sel_o;
  assign claim_s      = (state_q == S_IDLE) && (mode_q != MODE_OFF) && bank_ready_s[claim_bank_s];
  assign release_s    = (state_q == S_TAIL1) && tx_ready_i;
  assign last_pix_s   = (rd_addr_q == AW'(NPIX - 1));
  assign sample_ext_s = 16'(sample_q);

  line_bank_arbiter u_arb (
    .clk            (clk),
    .rst_n          (rst_n),
    .cap_done_i     (cap_done_i),
    .claim_i        (claim_s),
    .claim_bank_i   (claim_bank_s),
    .release_i      (release_s),
    .release_bank_i (rd_bank_q),
    .cap_bank_sel_o (cap_bank_sel_o),
    .bank_ready_o   (bank_ready_s),
    .drop_cnt_o     (drop_cnt_o)
  );

  // A host command in the claim cycle overrides the single-shot disarm.
  always_comb begin
    mode_claim_s = ((state_q == S_IDLE) && claim_s && (mode_q == MODE_SINGLE)) ? MODE_OFF : mode_q;
    mode_d       = mode_claim_s;
    if (cmd_valid_i) begin
      case (cmd_data_i)
        CMD_SINGLE: mode_d = MODE_SINGLE;
        CMD_CONT:   mode_d = MODE_CONT;
        CMD_STOP:   mode_d = MODE_OFF;
        default:    mode_d = mode_claim_s;
      endcase
    end else begin
      mode_d = mode_claim_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = claim_s    ? S_SYNC0 : S_IDLE;
      S_SYNC0: state_d = tx_ready_i ? S_SYNC1 : S_SYNC0;
      S_SYNC1: state_d = tx_ready_i ? S_FETCH : S_SYNC1;
      S_FETCH: state_d = S_LOAD;
      S_LOAD:  state_d = S_LO;
      S_LO:    state_d = tx_ready_i ? S_HI : S_LO;
      S_HI: begin
        if (!tx_ready_i) begin
          state_d = S_HI;
        end else if (!last_pix_s) begin
          state_d = S_FETCH;
        end else begin
`ifdef FRAME_CSUM_EN
          state_d = S_CSUM;
`else
          state_d = S_TAIL0;
`endif
        end
      end
`ifdef FRAME_CSUM_EN
      S_CSUM:  state_d = tx_ready_i ? S_TAIL0 : S_CSUM;
`endif
      S_TAIL0: state_d = tx_ready_i ? S_TAIL1 : S_TAIL0;
      S_TAIL1: state_d = tx_ready_i ? S_IDLE : S_TAIL1;
      default: state_d = S_IDLE;
    endcase
  end

  // Byte outputs decode only state and held registers, so they stay stable under backpressure.
  always_comb begin
    tx_valid_o = 1'b0;
    tx_data_o  = 8'h00;
    rd_en_o    = 1'b0;
    case (state_q)
      S_SYNC0: begin tx_valid_o = 1'b1; tx_data_o = SYNC_HI; end
      S_SYNC1: begin tx_valid_o = 1'b1; tx_data_o = SYNC_LO; end
      S_FETCH: rd_en_o = 1'b1;
      S_LO:    begin tx_valid_o = 1'b1; tx_data_o = sample_q[7:0]; end
      S_HI:    begin tx_valid_o = 1'b1; tx_data_o = sample_ext_s[15:8]; end
`ifdef FRAME_CSUM_EN
      S_CSUM:  begin tx_valid_o = 1'b1; tx_data_o = csum_q; end
`endif
      S_TAIL0: begin tx_valid_o = 1'b1; tx_data_o = SYNC_LO; end
      S_TAIL1: begin tx_valid_o = 1'b1; tx_data_o = SYNC_HI; end
      default: begin tx_valid_o = 1'b0; tx_data_o = 8'h00; end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q      <= MODE_OFF;
      rd_bank_q   <= 1'b0;
      rd_addr_q   <= '0;
      sample_q    <= '0;
      busy_q      <= 1'b0;
      frame_cnt_q <= 16'd0;
`ifdef FRAME_CSUM_EN
      csum_q      <= 8'h00;
`endif
    end else begin
      mode_q <= mode_d;
      if (claim_s) begin
        rd_bank_q <= claim_bank_s;
        rd_addr_q <= '0;
        busy_q    <= 1'b1;
      end else if ((state_q == S_HI) && tx_ready_i && !last_pix_s) begin
        rd_addr_q <= rd_addr_q + AW'(1);
      end else if (release_s) begin
        busy_q      <= 1'b0;
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
      if (state_q == S_LOAD) begin
        sample_q <= rd_data_i;
      end
`ifdef FRAME_CSUM_EN
      if (claim_s) begin
        csum_q <= 8'h00;
      end else if (((state_q == S_LO) || (state_q == S_HI)) && tx_ready_i) begin
        csum_q <= csum_next(csum_q, tx_data_o);
      end
`endif
    end
  end

  assign rd_bank_o   = rd_bank_q;
  assign rd_addr_o   = rd_addr_q;
  assign busy_o      = busy_q;
  assign frame_cnt_o = frame_cnt_q;

endmodule

// File: tb/tb_line_frame_sequencer.sv
// Scoreboard bench for line_frame_sequencer: expected bytes are queued at stimulus
// time and a negedge monitor compares every accepted byte and checks stall stability.
module tb_line_frame_sequencer;
  import line_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic [7:0]    cmd_data = 8'h00;
  logic          cap_done = 1'b0;
  logic          cap_bank_sel;
  logic          rd_en;
  logic          rd_bank;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data = '0;
  logic          tx_valid;
  logic [7:0]    tx_data;
  logic          tx_ready = 1'b1;
  logic          busy;
  logic [15:0]   frame_cnt;
  logic [15:0]   drop_cnt;

  line_frame_sequencer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cmd_valid_i    (cmd_valid),
    .cmd_data_i     (cmd_data),
    .cap_done_i     (cap_done),
    .cap_bank_sel_o (cap_bank_sel),
    .rd_en_o        (rd_en),
    .rd_bank_o      (rd_bank),
    .rd_addr_o      (rd_addr),
    .rd_data_i      (rd_data),
    .tx_valid_o     (tx_valid),
    .tx_data_o      (tx_data),
    .tx_ready_i     (tx_ready),
    .busy_o         (busy),
    .frame_cnt_o    (frame_cnt),
    .drop_cnt_o     (drop_cnt)
  );

  always #5 clk = ~clk;

  logic [11:0] mem [2][256];
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_bank][rd_addr];

  logic [7:0] exp_q [$];
  int errors = 0;
  int checks = 0;
  int ready_mode = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // tx_ready: always high, or high one cycle in three
  initial begin
    int rcnt;
    rcnt = 0;
    forever begin
      @(posedge clk);
      #1;
      rcnt++;
      tx_ready = (ready_mode == 0) ? 1'b1 : ((rcnt % 3) == 0);
    end
  end

  // monitor
  initial begin
    logic       stall_pend;
    logic [7:0] stall_data;
    logic [7:0] e;
    stall_pend = 1'b0;
    stall_data = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_pend = 1'b0;
      end else begin
        if (stall_pend) chk("tx_hold", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, stall_data});
        if (tx_valid && tx_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_byte actual=%0h required=none", tx_data);
          end else begin
            e = exp_q.pop_front();
            chk("tx_byte", {24'd0, tx_data}, {24'd0, e});
          end
          stall_pend = 1'b0;
        end else if (tx_valid) begin
          stall_pend = 1'b1;
          stall_data = tx_data;
        end else begin
          stall_pend = 1'b0;
        end
      end
    end
  end

  task automatic fill(input int bank, input int kind, input int c);
    for (int i = 0; i < 256; i++) begin
      case (kind)
        0:       mem[bank][i] = 12'(i);
        1:       mem[bank][i] = 12'hABC;
        default: mem[bank][i] = 12'((i * 13 + c * 291) & 12'hFFF);
      endcase
    end
  endtask

  // csum_req < 0 means the bench computes the checksum itself
  task automatic push_frame(input int bank, input int csum_req);
    logic [7:0] lo, hi, cs;
    cs = 8'h00;
    exp_q.push_back(8'hC5);
    exp_q.push_back(8'hE3);
    for (int i = 0; i < 256; i++) begin
      lo = mem[bank][i][7:0];
      hi = {4'h0, mem[bank][i][11:8]};
      exp_q.push_back(lo);
      exp_q.push_back(hi);
      cs = cs ^ lo ^ hi;
    end
`ifdef FRAME_CSUM_EN
    exp_q.push_back((csum_req < 0) ? cs : 8'(csum_req));
`endif
    exp_q.push_back(8'hE3);
    exp_q.push_back(8'hC5);
  endtask

  task automatic send_cmd(input logic [7:0] b);
    cmd_valid = 1'b1;
    cmd_data  = b;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic pulse_cap();
    cap_done = 1'b1;
    tick();
    cap_done = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_sel"}, {31'd0, cap_bank_sel}, 32'd0);
    chk({tag, "_rd_en"}, {31'd0, rd_en}, 32'd0);
    chk({tag, "_rd_bank"}, {31'd0, rd_bank}, 32'd0);
    chk({tag, "_rd_addr"}, {24'd0, rd_addr}, 32'd0);
    chk({tag, "_tx_valid"}, {31'd0, tx_valid}, 32'd0);
    chk({tag, "_tx_data"}, {24'd0, tx_data}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_frame_cnt"}, {16'd0, frame_cnt}, 32'd0);
    chk({tag, "_drop_cnt"}, {16'd0, drop_cnt}, 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cap_done = 1'b0;
    ready_mode = 0;
    exp_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_drain(input string tag, input int max_cycles);
    int n;
    n = 0;
    while (((exp_q.size() != 0) || busy) && (n < max_cycles)) begin
      tick();
      n++;
    end
    chk({tag, "_pending_bytes"}, exp_q.size(), 32'd0);
    chk({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int sel_before [9];
    int sel_after [9];
    int c;
    sel_before = '{0, 1, 1, 1, 1, 0, 0, 0, 0};
    sel_after  = '{1, 1, 1, 1, 0, 0, 0, 0, 1};

    // reset state
    tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // single frame of ramp data from bank 0, then no second frame
    send_cmd(CMD_SINGLE);
    fill(0, 0, 0);
    push_frame(0, -1);
    pulse_cap();
    chk("single_sel_toggle", {31'd0, cap_bank_sel}, 32'd1);
    tick();
    chk("single_first_valid", {31'd0, tx_valid}, 32'd1);
    chk("single_busy", {31'd0, busy}, 32'd1);
    chk("single_rd_bank", {31'd0, rd_bank}, 32'd0);
    wait_drain("single", 3000);
    chk("single_frame_cnt", {16'd0, frame_cnt}, 32'd1);
    fill(1, 0, 0);
    pulse_cap();
    repeat (100) tick();
    chk("single_no_rearm_valid", {31'd0, tx_valid}, 32'd0);
    chk("single_no_rearm_cnt", {16'd0, frame_cnt}, 32'd1);
    chk("single_sel_back", {31'd0, cap_bank_sel}, 32'd0);

    // two lines without a command: older line dropped, newest sent on 0x10
    do_reset();
    fill(0, 2, 1);
    pulse_cap();
    chk("drop_sel1", {31'd0, cap_bank_sel}, 32'd1);
    fill(1, 2, 2);
    pulse_cap();
    chk("drop_sel0", {31'd0, cap_bank_sel}, 32'd0);
    chk("drop_cnt_one", {16'd0, drop_cnt}, 32'd1);
    chk("drop_idle_busy", {31'd0, busy}, 32'd0);
    push_frame(1, -1);
    send_cmd(CMD_SINGLE);
    wait_drain("newest", 3000);
    chk("newest_frame_cnt", {16'd0, frame_cnt}, 32'd1);

    // backpressure: same byte stream with tx_ready high one cycle in three
    do_reset();
    ready_mode = 1;
    send_cmd(CMD_SINGLE);
    fill(0, 0, 0);
    push_frame(0, -1);
    pulse_cap();
    wait_drain("stall", 6000);
    chk("stall_frame_cnt", {16'd0, frame_cnt}, 32'd1);
    ready_mode = 0;

    // continuous mode, capture every 300 cycles, stop during second frame
    do_reset();
    send_cmd(CMD_CONT);
    for (int n = 0; n <= 2700; n++) begin
      if (((n % 300) == 0) && (n <= 2400)) begin
        c = n / 300;
        fill(sel_before[c], 2, c + 10);
        if ((c == 0) || (c == 4)) push_frame(sel_before[c], -1);
        cap_done = 1'b1;
      end
      if (n == 1610) begin
        cmd_valid = 1'b1;
        cmd_data  = CMD_STOP;
      end
      if (n == 1199) chk("cont_drop_during_send", {16'd0, drop_cnt}, 32'd3);
      tick();
      if (cap_done) chk("cont_sel", {31'd0, cap_bank_sel}, 32'(sel_after[n / 300]));
      cap_done  = 1'b0;
      cmd_valid = 1'b0;
    end
    chk("cont_pending_bytes", exp_q.size(), 32'd0);
    chk("cont_busy_end", {31'd0, busy}, 32'd0);
    chk("cont_tx_valid_end", {31'd0, tx_valid}, 32'd0);
    chk("cont_frame_cnt", {16'd0, frame_cnt}, 32'd2);
    chk("cont_drop_cnt", {16'd0, drop_cnt}, 32'd6);

    // reset at pixel 50 abandons the frame; next frame restarts with sync
    do_reset();
    send_cmd(CMD_SINGLE);
    fill(0, 0, 0);
    push_frame(0, -1);
    pulse_cap();
    repeat (1 + 2 + 50 * 4) tick();
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check_reset_outputs("midreset");
    tick();
    rst_n = 1'b1;
    tick();
    send_cmd(CMD_SINGLE);
    fill(0, 1, 0);
    push_frame(0, 8'h00);
    pulse_cap();
    wait_drain("after_reset", 3000);
    chk("after_reset_frame_cnt", {16'd0, frame_cnt}, 32'd1);
    chk("after_reset_drop_cnt", {16'd0, drop_cnt}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
